// File: rtl/dct_ctrl_pkg.sv
// Shared types and constants for the DCT frame scheduler: FSM encoding,
// block geometry and the watchdog sizing helper.
package dct_ctrl_pkg;

  localparam int BLOCK_SIZE             = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // One spare bit so the counter can represent the limit value itself.
  function automatic int wd_width(input int timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

endpackage

// File: rtl/block_coord_counter.sv
// Raster block-coordinate counter with a latched frame bound; reports when
// the current position is the final block of the frame.
module block_coord_counter
  import dct_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_w,
  input  logic [CNT_W-1:0] i_h,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_is_last
);

  logic [CNT_W-1:0] r_w;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_end;
  logic             w_y_end;

  // Bound-minus-one stays in CNT_W bits, so a full-range bound works.
  assign w_x_end   = (r_x == (r_w - CNT_W'(1)));
  assign w_y_end   = (r_y == (r_h - CNT_W'(1)));
  assign o_is_last = w_x_end && w_y_end;
  assign o_x       = r_x;
  assign o_y       = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
      r_h <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_w <= i_w;
      r_h <= i_h;
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= r_y + CNT_W'(1);
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Frame-level controller for the 2-D DCT engine: pulls blocks from upstream,
// sequences load/start/done per block and presents results to the quantizer.
module dct_block_scheduler
  import dct_ctrl_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_blocks_w,
  input  logic [CNT_W-1:0] cfg_blocks_h,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             blk_load_en,
  output logic             dct_start,
  input  logic             dct_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_blk_x,
  output logic [CNT_W-1:0] out_blk_y,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_cfg
);

  localparam int              WD_W     = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WD_W-1:0]  r_wd;
  logic [WD_W-1:0]  w_wd_inc;
  logic             r_err_timeout;
  logic             r_err_cfg;
  logic             r_frame_done;
  logic             w_cfg_ok;
  logic             w_cfg_accept;
  logic             w_cfg_bad;
  logic             w_abort;
  logic             w_accept;
  logic             w_timeout;
  logic             w_is_last;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;

  assign w_cfg_ok     = (cfg_blocks_w != '0) && (cfg_blocks_h != '0);
  assign w_cfg_accept = (r_state == ST_IDLE) && cfg_valid && w_cfg_ok;
  assign w_cfg_bad    = (r_state == ST_IDLE) && cfg_valid && !w_cfg_ok;
  assign w_abort      = abort && (r_state != ST_IDLE);
  assign w_accept     = (r_state == ST_HOLD) && out_ready;
  assign w_wd_inc     = r_wd + WD_W'(1);
  assign w_timeout    = (w_wd_inc == WD_LIMIT);

  block_coord_counter #(
    .CNT_W(CNT_W)
  ) u_coord (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_cfg_accept),
    .i_w      (cfg_blocks_w),
    .i_h      (cfg_blocks_h),
    .i_clear  (w_abort || (w_accept && w_is_last)),
    .i_advance(w_accept && !w_is_last && !w_abort),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_is_last(w_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_cfg_accept) w_state_next = ST_WAIT_IN;
      ST_WAIT_IN: if (in_valid) w_state_next = ST_START;
      ST_START:   w_state_next = ST_RUN;
      ST_RUN: begin
        // A done arriving on the timeout cycle still counts as success.
        if (dct_done)       w_state_next = ST_HOLD;
        else if (w_timeout) w_state_next = ST_ERROR;
      end
      ST_HOLD:    if (out_ready) w_state_next = w_is_last ? ST_IDLE : ST_WAIT_IN;
      ST_ERROR:   w_state_next = ST_ERROR;
      default:    w_state_next = ST_IDLE;
    endcase
    if (w_abort) w_state_next = ST_IDLE;
  end

  always_comb begin
    cfg_ready   = (r_state == ST_IDLE);
    in_ready    = (r_state == ST_WAIT_IN);
    blk_load_en = (r_state == ST_WAIT_IN) && in_valid;
    dct_start   = (r_state == ST_START);
    out_valid   = (r_state == ST_HOLD);
    out_last    = (r_state == ST_HOLD) && w_is_last;
    busy        = (r_state != ST_IDLE);
  end

  assign out_blk_x   = w_x;
  assign out_blk_y   = w_y;
  assign frame_done  = r_frame_done;
  assign err_timeout = r_err_timeout;
  assign err_cfg     = r_err_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd          <= '0;
      r_err_timeout <= 1'b0;
      r_err_cfg     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_wd         <= (r_state == ST_RUN) ? w_wd_inc : '0;
      r_err_cfg    <= w_cfg_bad;
      r_frame_done <= w_accept && w_is_last && !w_abort;
      if (w_abort)
        r_err_timeout <= 1'b0;
      else if ((r_state == ST_RUN) && !dct_done && w_timeout)
        r_err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Scoreboard bench for dct_block_scheduler: a behavioural engine model answers
// dct_start, expected block coordinates are queued at configuration time.
module tb_dct_block_scheduler;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       last;
  } blk_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_blocks_w = '0;
  logic [CNT_W-1:0] cfg_blocks_h = '0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             blk_load_en;
  logic             dct_start;
  logic             dct_done;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_blk_x;
  logic [CNT_W-1:0] out_blk_y;
  logic             out_last;
  logic             frame_done;
  logic             busy;
  logic             err_timeout;
  logic             err_cfg;

  logic eng_done = 1'b0;
  logic spur_done = 1'b0;
  int   eng_lat = 66;

  blk_t exp_q[$];
  blk_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   n_start = 0;
  int   base_start;
  int   to_cnt;
  logic [7:0] x0, y0;

  assign dct_done = eng_done | spur_done;

  dct_block_scheduler #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_blocks_w(cfg_blocks_w), .cfg_blocks_h(cfg_blocks_h),
    .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .blk_load_en(blk_load_en), .dct_start(dct_start), .dct_done(dct_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_blk_x(out_blk_x), .out_blk_y(out_blk_y), .out_last(out_last),
    .frame_done(frame_done), .busy(busy),
    .err_timeout(err_timeout), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: done pulses eng_lat cycles after the start cycle; negative = never.
  initial forever begin
    @(negedge clk);
    if (dct_start && eng_lat >= 0) begin
      repeat (eng_lat) @(posedge clk);
      #1 eng_done = 1'b1;
      @(posedge clk);
      #1 eng_done = 1'b0;
    end
  end

  // Output monitor: each accepted block is checked against the queue head.
  initial forever begin
    @(negedge clk);
    if (dct_start) n_start++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("blk_x", out_blk_x, mon_e.x);
        check_eq("blk_y", out_blk_y, mon_e.y);
        check_eq("blk_last", out_last, mon_e.last);
      end
      last_acc_cyc = cyc;
      $display("block accepted x=%0d y=%0d last=%0d cyc=%0d", out_blk_x, out_blk_y, out_last, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int w, input int h);
    step();
    cfg_valid    = 1'b1;
    cfg_blocks_w = 8'(w);
    cfg_blocks_h = 8'(h);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        exp_q.push_back('{x: 8'(xx), y: 8'(yy), last: (xx == w - 1 && yy == h - 1)});
    $display("cfg w=%0d h=%0d cyc=%0d", w, h, cyc);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_eq(tag, (i < budget), 1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dct_start) break;
    end
    check_eq(tag, (i < budget), 1);
  endtask

  task automatic wait_frame_done(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    check_eq(tag, (i < budget), 1);
    if (i < budget) begin
      check_eq({tag, "_gap"}, cyc - last_acc_cyc, 1);
      $display("frame_done cyc=%0d", cyc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {cfg_ready, busy, in_ready, blk_load_en, dct_start, out_valid,
                          out_last, frame_done, err_timeout, err_cfg},
             10'b10_0000_0000);
    check_eq("rst_coords", {out_blk_x, out_blk_y}, 0);
    step();
    rst_n = 1'b1;

    // T1: 2x1 frame, free-flowing
    in_valid  = 1'b1;
    out_ready = 1'b1;
    base_start = n_start;
    send_cfg(2, 1);
    wait_frame_done(400, "t1_fd");
    check_eq("t1_starts", n_start - base_start, 2);
    @(negedge clk);
    check_eq("t1_idle", {cfg_ready, busy, frame_done}, 3'b100);

    // T2: 3x2 frame with downstream stalls
    out_ready = 1'b0;
    send_cfg(3, 2);
    for (int b = 0; b < 6; b++) begin
      wait_out_valid(200, "t2_ov");
      x0 = out_blk_x;
      y0 = out_blk_y;
      repeat (10) begin
        @(negedge clk);
        check_eq("t2_hold", {out_valid, in_ready, dct_start, blk_load_en, out_blk_x, out_blk_y},
                 {1'b1, 1'b0, 1'b0, 1'b0, x0, y0});
      end
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    wait_frame_done(50, "t2_fd");

    // T3: engine never finishes -> watchdog
    eng_lat   = -1;
    out_ready = 1'b1;
    send_cfg(1, 1);
    exp_q.delete();
    wait_start(50, "t3_start");
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      to_cnt++;
      if (err_timeout) break;
    end
    check_eq("t3_to_cycles", to_cnt, 128);
    check_eq("t3_err_state", {busy, cfg_ready, in_ready, out_valid, dct_start}, 5'b10000);
    repeat (20) @(negedge clk);
    check_eq("t3_sticky", {err_timeout, busy}, 2'b11);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check_eq("t3_abort", {err_timeout, cfg_ready, busy}, 3'b010);

    // T4: zero-dimension config, then a single-block frame
    eng_lat = 66;
    send_cfg(0, 5);
    @(negedge clk);
    check_eq("t4_errcfg", {err_cfg, busy, cfg_ready}, 3'b101);
    @(negedge clk);
    check_eq("t4_errcfg_pulse", {err_cfg, busy}, 2'b00);
    send_cfg(1, 1);
    wait_frame_done(300, "t4_fd");

    // T5: done on the timeout boundary, then a spurious done in WAIT_IN
    eng_lat = 127;
    send_cfg(1, 1);
    wait_frame_done(400, "t5_fd");
    check_eq("t5_no_err", err_timeout, 0);
    eng_lat  = 66;
    in_valid = 1'b0;
    send_cfg(1, 1);
    @(negedge clk);
    check_eq("t5_wait_in", {in_ready, blk_load_en}, 2'b10);
    step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_spurious", {in_ready, out_valid, dct_start, busy}, 4'b1001);
    step();
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("t5_load_en", {in_ready, blk_load_en}, 2'b11);
    wait_frame_done(300, "t5b_fd");

    // T6: async reset mid-RUN, then abort racing the last-block accept
    send_cfg(2, 2);
    wait_start(50, "t6_start");
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst", {cfg_ready, busy, out_valid, dct_start, in_ready, err_timeout, frame_done},
             7'b1000000);
    check_eq("t6_rst_xy", {out_blk_x, out_blk_y}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (80) @(negedge clk);
    check_eq("t6_post_rst", {cfg_ready, busy}, 2'b10);

    out_ready = 1'b0;
    send_cfg(1, 1);
    wait_out_valid(200, "t6_ov");
    step();
    out_ready = 1'b1;
    abort     = 1'b1;
    step();
    out_ready = 1'b0;
    abort     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("t6_no_fd", frame_done, 0);
    end
    check_eq("t6_idle", {cfg_ready, busy, out_valid}, 3'b100);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
